// File: rtl/ctrl_pkg.sv
// Shared encodings and the control-word type for the pipelined MIPS control unit.
package ctrl_pkg;

    localparam int CTRL_ALUOP_W = 4;
    localparam int CTRL_REG_W   = 5;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;
    localparam logic [3:0] ALU_BLTZ = 4'b1001;
    localparam logic [3:0] ALU_BGTZ = 4'b1010;
    localparam logic [3:0] ALU_BEQ  = 4'b1011;
    localparam logic [3:0] ALU_BLEZ = 4'b1101;
    localparam logic [3:0] ALU_BGEZ = 4'b1110;
    localparam logic [3:0] ALU_BNE  = 4'b1111;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_BYTE = 2'b10
    } mem_size_e;

    typedef struct packed {
        logic [CTRL_ALUOP_W-1:0] alu_op;
        logic                    alu_src;
        logic                    to_branch;
        logic                    jump;
        logic                    jump_reg;
        logic                    mem_read;
        logic                    mem_write;
        mem_size_e               mem_size;
        logic                    reg_write;
        logic                    mem_to_reg;
        logic                    link;
        logic [CTRL_REG_W-1:0]   write_reg;
    } ctrl_word_t;

    localparam ctrl_word_t BUBBLE = '0;

endpackage

// File: rtl/pipe_control_unit_if.sv
// ID-stage request and staged control outputs of the pipelined control unit.
// EX_IllegalOp exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface pipe_control_unit_if #(
    parameter int INSTR_W    = 32,
    parameter int ALUOP_W    = 4,
    parameter int REG_ADDR_W = 5
);
    logic [INSTR_W-1:0]    Instruction;
    logic                  InstrValid;
    logic                  Flush;
    logic                  Stall;
    logic [ALUOP_W-1:0]    EX_ALUOp;
    logic                  EX_ALUSrc;
    logic                  EX_ToBranch;
    logic                  EX_Jump;
    logic                  EX_JumpReg;
    logic                  MEM_MemRead;
    logic                  MEM_MemWrite;
    logic [1:0]            MEM_Size;
    logic                  WB_RegWrite;
    logic                  WB_MemToReg;
    logic                  WB_Link;
    logic [REG_ADDR_W-1:0] WB_WriteReg;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic                  EX_IllegalOp;
`endif

    // master: IF/ID register and datapath side
    modport master (
        output Instruction, InstrValid, Flush,
        input  Stall, EX_ALUOp, EX_ALUSrc, EX_ToBranch, EX_Jump, EX_JumpReg,
        input  MEM_MemRead, MEM_MemWrite, MEM_Size,
`ifdef CTRL_ILLEGAL_TRAP_EN
        input  EX_IllegalOp,
`endif
        input  WB_RegWrite, WB_MemToReg, WB_Link, WB_WriteReg
    );

    modport slave (
        input  Instruction, InstrValid, Flush,
        output Stall, EX_ALUOp, EX_ALUSrc, EX_ToBranch, EX_Jump, EX_JumpReg,
        output MEM_MemRead, MEM_MemWrite, MEM_Size,
`ifdef CTRL_ILLEGAL_TRAP_EN
        output EX_IllegalOp,
`endif
        output WB_RegWrite, WB_MemToReg, WB_Link, WB_WriteReg
    );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational MIPS decode of one instruction into a control word, plus the
// register-source flags used by load-use detection and an illegal-encoding flag.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int LINK_REG = 31
) (
    input  logic [31:0] instr,
    output ctrl_word_t  word,
    output logic        uses_rs,
    output logic        uses_rt,
    output logic        illegal
);

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [CTRL_REG_W-1:0] rt;
    logic [CTRL_REG_W-1:0] rd;
    logic [CTRL_REG_W-1:0] dest;
    logic                  unused_shamt;

    assign opcode       = instr[31:26];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        word    = BUBBLE;
        uses_rs = 1'b1;
        uses_rt = 1'b0;
        illegal = 1'b0;
        dest    = '0;
        case (opcode)
            OP_RTYPE: begin
                uses_rt         = 1'b1;
                word.reg_write  = 1'b1;
                word.mem_to_reg = 1'b1;
                dest            = rd;
                case (funct)
                    FN_ADD: word.alu_op = ALU_ADD;
                    FN_SUB: word.alu_op = ALU_SUB;
                    FN_AND: word.alu_op = ALU_AND;
                    FN_OR:  word.alu_op = ALU_OR;
                    FN_NOR: word.alu_op = ALU_NOR;
                    FN_XOR: word.alu_op = ALU_XOR;
                    FN_SLT: word.alu_op = ALU_SLT;
                    FN_SLL: begin word.alu_op = ALU_SLL; word.alu_src = 1'b1; end
                    FN_SRL: begin word.alu_op = ALU_SRL; word.alu_src = 1'b1; end
                    FN_JR: begin
                        word.alu_op     = ALU_ADD;
                        word.jump       = 1'b1;
                        word.jump_reg   = 1'b1;
                        word.reg_write  = 1'b0;
                        word.mem_to_reg = 1'b0;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                word.to_branch = 1'b1;
                word.alu_op    = rt[0] ? ALU_BGEZ : ALU_BLTZ;
            end
            OP_J: begin
                uses_rs   = 1'b0;
                word.jump = 1'b1;
            end
            OP_JAL: begin
                uses_rs        = 1'b0;
                word.jump      = 1'b1;
                word.link      = 1'b1;
                word.reg_write = 1'b1;
                dest           = CTRL_REG_W'(LINK_REG);
            end
            OP_BEQ, OP_BNE: begin
                uses_rt        = 1'b1;
                word.to_branch = 1'b1;
                word.alu_op    = (opcode == OP_BEQ) ? ALU_BEQ : ALU_BNE;
            end
            OP_BLEZ: begin word.to_branch = 1'b1; word.alu_op = ALU_BLEZ; end
            OP_BGTZ: begin word.to_branch = 1'b1; word.alu_op = ALU_BGTZ; end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                word.alu_src    = 1'b1;
                word.reg_write  = 1'b1;
                word.mem_to_reg = 1'b1;
                dest            = rt;
                case (opcode)
                    OP_SLTI: word.alu_op = ALU_SLT;
                    OP_ANDI: word.alu_op = ALU_AND;
                    OP_ORI:  word.alu_op = ALU_OR;
                    OP_XORI: word.alu_op = ALU_XOR;
                    default: word.alu_op = ALU_ADD;
                endcase
            end
            OP_LW, OP_LH, OP_LB: begin
                word.alu_src   = 1'b1;
                word.mem_read  = 1'b1;
                word.reg_write = 1'b1;
                dest           = rt;
                word.mem_size  = (opcode == OP_LW) ? SIZE_WORD :
                                 (opcode == OP_LH) ? SIZE_HALF : SIZE_BYTE;
            end
            OP_SW, OP_SH, OP_SB: begin
                uses_rt        = 1'b1;
                word.alu_src   = 1'b1;
                word.mem_write = 1'b1;
                word.mem_size  = (opcode == OP_SW) ? SIZE_WORD :
                                 (opcode == OP_SH) ? SIZE_HALF : SIZE_BYTE;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            word    = BUBBLE;
            uses_rs = 1'b0;
            uses_rt = 1'b0;
        end

        // $0 is hard-wired: a write to it is no write at all
        if (word.reg_write && dest != '0) begin
            word.write_reg = dest;
        end else begin
            word.reg_write = 1'b0;
            word.write_reg = '0;
        end
    end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined MIPS control: ID decode, ID/EX -> EX/MEM -> MEM/WB control registers,
// load-use stall and bubble insertion. CTRL_ILLEGAL_TRAP_EN adds EX_IllegalOp.
module pipe_control_unit
    import ctrl_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int ALUOP_W    = 4,
    parameter int REG_ADDR_W = 5,
    parameter int LINK_REG   = 31
) (
    input logic Clk,
    input logic Reset,
    pipe_control_unit_if.slave bus
);

    logic [INSTR_W-1:0]    instr;
    ctrl_word_t            dec_word;
    logic                  uses_rs;
    logic                  uses_rt;
    logic                  illegal;
    logic [CTRL_REG_W-1:0] rs;
    logic [CTRL_REG_W-1:0] rt;
    logic                  load_use;
    logic                  stall;
    logic                  kill;
    ctrl_word_t            ex_p0;
    ctrl_word_t            mem_p1;
    ctrl_word_t            wb_p2;

    assign instr = bus.Instruction;
    assign rs    = instr[25:21];
    assign rt    = instr[20:16];

    ctrl_decoder #(
        .LINK_REG (LINK_REG)
    ) u_decoder (
        .instr   (instr[31:0]),
        .word    (dec_word),
        .uses_rs (uses_rs),
        .uses_rt (uses_rt),
        .illegal (illegal)
    );

    // write_reg is already 0 for non-writing and $0-targeting loads
    assign load_use = ex_p0.mem_read && (ex_p0.write_reg != '0) &&
                      ((uses_rs && rs == ex_p0.write_reg) ||
                       (uses_rt && rt == ex_p0.write_reg));
    assign stall    = bus.InstrValid && !bus.Flush && load_use;
    assign kill     = !bus.InstrValid || bus.Flush || stall;

    // ID -> EX -> MEM -> WB
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ex_p0  <= BUBBLE;
            mem_p1 <= BUBBLE;
            wb_p2  <= BUBBLE;
        end else begin
            ex_p0  <= kill ? BUBBLE : dec_word;
            mem_p1 <= ex_p0;
            wb_p2  <= mem_p1;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic ill_p0;

    always_ff @(posedge Clk) begin
        if (Reset) ill_p0 <= 1'b0;
        else       ill_p0 <= illegal && !kill;
    end

    assign bus.EX_IllegalOp = ill_p0;
`else
    logic unused_illegal;
    assign unused_illegal = illegal;
`endif

    assign bus.Stall        = stall;
    assign bus.EX_ALUOp     = ALUOP_W'(ex_p0.alu_op);
    assign bus.EX_ALUSrc    = ex_p0.alu_src;
    assign bus.EX_ToBranch  = ex_p0.to_branch;
    assign bus.EX_Jump      = ex_p0.jump;
    assign bus.EX_JumpReg   = ex_p0.jump_reg;
    assign bus.MEM_MemRead  = mem_p1.mem_read;
    assign bus.MEM_MemWrite = mem_p1.mem_write;
    assign bus.MEM_Size     = mem_p1.mem_size;
    assign bus.WB_RegWrite  = wb_p2.reg_write;
    assign bus.WB_MemToReg  = wb_p2.mem_to_reg;
    assign bus.WB_Link      = wb_p2.link;
    assign bus.WB_WriteReg  = REG_ADDR_W'(wb_p2.write_reg);

endmodule

// File: tb/tb_pipe_control_unit.sv
// Bench for pipe_control_unit: directed instruction stream against a queue-based
// pipeline model with hand-decoded expected control words.
module tb_pipe_control_unit;

    typedef struct packed {
        logic [3:0] alu;
        logic       src, br, jmp, jr, mr, mw;
        logic [1:0] sz;
        logic       rw, mtr, lnk;
        logic [4:0] wr;
        logic       ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] ins;
        logic        vld, fl, urs, urt, ill;
        exp_t        w;
    } vec_t;

    localparam exp_t BUB = '0;

    logic Clk = 1'b0;
    logic Reset;

    pipe_control_unit_if bus ();

    pipe_control_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    bit   last_stall = 1'b0;
    exp_t pipe[$];
    vec_t cur;

    vec_t IDLE, ADD1, LW4, ADD5, LW1, BEQ, BEQF, JAL, ADDI0, SB, SUB, BGEZ, BLTZ;
    vec_t SLL, ORI, JR, ILLOP, ILLFN, INV, SW4, ADDI4, LW0, ADDZ;

    function automatic exp_t mk(logic [3:0] alu, logic src, logic br, logic jmp, logic jr,
                                logic mr, logic mw, logic [1:0] sz, logic rw, logic mtr,
                                logic lnk, logic [4:0] wr);
        exp_t e;
        e.alu = alu; e.src = src; e.br = br; e.jmp = jmp; e.jr = jr;
        e.mr = mr; e.mw = mw; e.sz = sz; e.rw = rw; e.mtr = mtr; e.lnk = lnk;
        e.wr = wr; e.ill = 1'b0;
        return e;
    endfunction

    function automatic vec_t v(logic [31:0] ins, logic urs, logic urt, logic ill, exp_t w);
        vec_t r;
        r.ins = ins; r.vld = 1'b1; r.fl = 1'b0;
        r.urs = urs; r.urt = urt; r.ill = ill; r.w = w;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Load-use rule: the word now in EX is a load to a nonzero register that
    // the ID instruction reads as a source.
    function automatic bit m_stall();
        exp_t       e;
        logic [4:0] rs;
        logic [4:0] rt;
        e  = pipe[0];
        rs = cur.ins[25:21];
        rt = cur.ins[20:16];
        return cur.vld && !cur.fl && e.mr && (e.wr != 5'd0) &&
               ((cur.urs && rs == e.wr) || (cur.urt && rt == e.wr));
    endfunction

    function automatic logic [31:0] all_outs();
        return {11'd0, bus.EX_ALUOp, bus.EX_ALUSrc, bus.EX_ToBranch, bus.EX_Jump,
                bus.EX_JumpReg, bus.MEM_MemRead, bus.MEM_MemWrite, bus.MEM_Size,
                bus.WB_RegWrite, bus.WB_MemToReg, bus.WB_Link, bus.WB_WriteReg, bus.Stall};
    endfunction

    task automatic compare_cycle();
        exp_t ex, mem, wb;
        ex  = pipe[0];
        mem = pipe[1];
        wb  = pipe[2];
        last_stall = m_stall();
        check("ex_stage", {bus.EX_ALUOp, bus.EX_ALUSrc, bus.EX_ToBranch, bus.EX_Jump, bus.EX_JumpReg},
                          {ex.alu, ex.src, ex.br, ex.jmp, ex.jr});
        check("mem_stage", {bus.MEM_MemRead, bus.MEM_MemWrite, bus.MEM_Size},
                           {mem.mr, mem.mw, mem.sz});
        check("wb_stage", {bus.WB_RegWrite, bus.WB_MemToReg, bus.WB_Link, bus.WB_WriteReg},
                          {wb.rw, wb.mtr, wb.lnk, wb.wr});
        check("stall", bus.Stall, last_stall);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("ex_illegal", bus.EX_IllegalOp, ex.ill);
`endif
    endtask

    task automatic step();
        exp_t acc;
        @(negedge Clk);
        if (chk_en) compare_cycle();
        else last_stall = 1'b0;
        @(posedge Clk);
        if (Reset) begin
            pipe.delete();
            repeat (3) pipe.push_back(BUB);
        end else begin
            acc     = (last_stall || !cur.vld || cur.fl) ? BUB : cur.w;
            acc.ill = (!last_stall && cur.vld && !cur.fl) ? cur.ill : 1'b0;
            pipe.push_front(acc);
            void'(pipe.pop_back());
        end
        #1;
    endtask

    task automatic drive(vec_t x);
        cur             = x;
        bus.Instruction = x.ins;
        bus.InstrValid  = x.vld;
        bus.Flush       = x.fl;
    endtask

    // The bench acts as IF/ID: a stalled instruction is held for one more cycle.
    task automatic issue(vec_t x);
        drive(x);
        step();
        if (last_stall) step();
    endtask

    initial begin
        IDLE  = '0;
        ADD1  = v(32'h00221820, 1, 1, 0, mk(4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 5'd3));
        LW4   = v(32'h8C240000, 1, 0, 0, mk(4'b0000, 1, 0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 5'd4));
        ADD5  = v(32'h00822820, 1, 1, 0, mk(4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 5'd5));
        LW1   = v(32'h8C410000, 1, 0, 0, mk(4'b0000, 1, 0, 0, 0, 1, 0, 2'b00, 1, 0, 0, 5'd1));
        BEQ   = v(32'h10220004, 1, 1, 0, mk(4'b1011, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 5'd0));
        BEQF  = BEQ;
        BEQF.fl = 1'b1;
        JAL   = v(32'h0C000010, 0, 0, 0, mk(4'b0000, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0, 1, 5'd31));
        ADDI0 = v(32'h20200005, 1, 0, 0, mk(4'b0000, 1, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0, 5'd0));
        SB    = v(32'hA0620001, 1, 1, 0, mk(4'b0000, 1, 0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 5'd0));
        SUB   = v(32'h00E83022, 1, 1, 0, mk(4'b0001, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 5'd6));
        BGEZ  = v(32'h04610008, 1, 0, 0, mk(4'b1110, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 5'd0));
        BLTZ  = v(32'h04600008, 1, 0, 0, mk(4'b1001, 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 5'd0));
        SLL   = v(32'h000A4900, 1, 1, 0, mk(4'b0111, 1, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 5'd9));
        ORI   = v(32'h358B00FF, 1, 0, 0, mk(4'b0100, 1, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 5'd11));
        JR    = v(32'h03E00008, 1, 1, 0, mk(4'b0000, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 5'd0));
        ILLOP = v(32'hFC000000, 0, 0, 1, BUB);
        ILLFN = v(32'h0000003F, 0, 0, 1, BUB);
        INV   = ADD1;
        INV.vld = 1'b0;
        SW4   = v(32'hACA40000, 1, 1, 0, mk(4'b0000, 1, 0, 0, 0, 0, 1, 2'b00, 0, 0, 0, 5'd0));
        ADDI4 = v(32'h20240001, 1, 0, 0, mk(4'b0000, 1, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 5'd4));
        LW0   = v(32'h8C200000, 1, 0, 0, mk(4'b0000, 1, 0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 5'd0));
        ADDZ  = v(32'h00001820, 1, 1, 0, mk(4'b0000, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 5'd3));

        repeat (3) pipe.push_back(BUB);
        Reset = 1'b1;
        drive(IDLE);
        step();
        step();
        check("reset_outputs", all_outs(), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("reset_illegal", bus.EX_IllegalOp, 32'd0);
`endif
        Reset  = 1'b0;
        chk_en = 1'b1;

        issue(ADD1);
        check("add_ex", {bus.EX_ALUOp, bus.EX_ALUSrc}, 32'd0);
        drive(IDLE);
        step();
        step();
        check("add_wb", {bus.WB_RegWrite, bus.WB_WriteReg, bus.WB_MemToReg}, {1'b1, 5'd3, 1'b1});

        issue(LW4);
        drive(ADD5);
        #1 check("load_use_stall", bus.Stall, 32'd1);
        step();
        #1 check("stall_drops", bus.Stall, 32'd0);
        step();
        check("wb_seq_lw", bus.WB_WriteReg, 32'd4);
        drive(IDLE);
        step();
        check("wb_seq_bubble", bus.WB_WriteReg, 32'd0);
        step();
        check("wb_seq_add", bus.WB_WriteReg, 32'd5);

        issue(LW1);
        drive(BEQF);
        #1 check("flush_beats_stall", bus.Stall, 32'd0);
        step();
        check("flush_bubble", {bus.EX_ALUOp, bus.EX_ToBranch, bus.EX_Jump}, 32'd0);
        issue(BEQ);

        issue(JAL);
        check("jal_ex_jump", bus.EX_Jump, 32'd1);
        drive(IDLE);
        step();
        step();
        check("jal_wb", {bus.WB_Link, bus.WB_RegWrite, bus.WB_WriteReg}, {1'b1, 1'b1, 5'd31});

        issue(ADDI0);
        issue(SB);
        drive(IDLE);
        step();
        check("sb_mem", {bus.MEM_MemWrite, bus.MEM_Size}, 32'b110);
        check("addi_r0_wb", bus.WB_RegWrite, 32'd0);

        issue(SUB);
        issue(BGEZ);
        issue(BLTZ);
        issue(SLL);
        issue(ORI);
        issue(JR);
        issue(ILLFN);
        issue(INV);
        issue(ILLOP);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("illegal_set", bus.EX_IllegalOp, 32'd1);
`endif
        drive(IDLE);
        step();
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("illegal_clear", bus.EX_IllegalOp, 32'd0);
`endif

        issue(LW4);
        issue(SW4);
        issue(LW4);
        drive(ADDI4);
        #1 check("rt_dest_no_stall", bus.Stall, 32'd0);
        step();
        issue(LW0);
        drive(ADDZ);
        #1 check("r0_load_no_stall", bus.Stall, 32'd0);
        step();

        issue(SW4);
        Reset = 1'b1;
        drive(IDLE);
        step();
        check("midreset_outputs", all_outs(), 32'd0);
        check("midreset_store_dropped", bus.MEM_MemWrite, 32'd0);
        Reset = 1'b0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
